// File: rtl/cmp_result_packer_if.sv
// Stream bundle for the compare-result packer: a 32-bit code input stream
// and a packed-word output stream, each with a valid/ready handshake.
interface cmp_result_packer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_mask;
  logic [5:0]  out_count;
  logic [5:0]  out_ones;
  logic        out_last;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_mask, out_count, out_ones, out_last
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_mask, out_count, out_ones, out_last
  );
endinterface

// File: rtl/cmp_result_packer.sv
// Packs a stream of compare result codes into up to 32-bit masks (first result
// in bit 0), with per-word bit count, ones count, group-end flag and error flag.
module cmp_result_packer #(
  parameter logic [31:0] CODE_TRUE  = 32'h3F800000,
  parameter logic [31:0] CODE_FALSE = 32'h33D6BF95
) (
  input  logic                 clk,
  input  logic                 rst,
  cmp_result_packer_if.slave   bus,
  output logic                 err_code,
  output logic [15:0]          word_cnt
);

  typedef enum logic {EMPTY, FILL} state_t;

  state_t      state_q;
  logic [31:0] acc_q, acc_d;
  logic [5:0]  fill_q, fill_d;
  logic [5:0]  ones_q, ones_d;
  logic        out_valid_q, out_last_q, err_q;
  logic [31:0] out_mask_q;
  logic [5:0]  out_count_q, out_ones_q;
  logic [15:0] word_cnt_q;

  logic in_ready_w, in_xfer, out_xfer, bit_w, illegal_w, complete_w;

  always_comb begin
    in_ready_w = !(out_valid_q && !bus.out_ready);
    in_xfer    = bus.in_valid && in_ready_w;
    out_xfer   = out_valid_q && bus.out_ready;
    bit_w      = (bus.in_data == CODE_TRUE);
    illegal_w  = !bit_w && (bus.in_data != CODE_FALSE);
    // An EMPTY accumulator contributes nothing, so the new bit lands on a clean word
    acc_d      = ((state_q == EMPTY) ? 32'd0 : acc_q) | ({31'd0, bit_w} << fill_q[4:0]);
    fill_d     = fill_q + 6'd1;
    ones_d     = ones_q + {5'd0, bit_w};
    complete_w = in_xfer && (bus.in_last || (fill_q == 6'd31));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      acc_q       <= '0;
      fill_q      <= '0;
      ones_q      <= '0;
      out_valid_q <= 1'b0;
      out_mask_q  <= '0;
      out_count_q <= '0;
      out_ones_q  <= '0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      if (out_xfer) begin
        out_valid_q <= 1'b0;
        if (word_cnt_q != 16'hFFFF) word_cnt_q <= word_cnt_q + 16'd1;
      end
      if (in_xfer) begin
        if (illegal_w) err_q <= 1'b1;
        if (complete_w) begin
          // Loading here also covers the no-bubble case: this set overrides the drop above
          out_valid_q <= 1'b1;
          out_mask_q  <= acc_d;
          out_count_q <= fill_d;
          out_ones_q  <= ones_d;
          out_last_q  <= bus.in_last;
          acc_q       <= '0;
          fill_q      <= '0;
          ones_q      <= '0;
          state_q     <= EMPTY;
        end else begin
          acc_q   <= acc_d;
          fill_q  <= fill_d;
          ones_q  <= ones_d;
          state_q <= FILL;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.out_mask  = out_mask_q;
  assign bus.out_count = out_count_q;
  assign bus.out_ones  = out_ones_q;
  assign bus.out_last  = out_last_q;
  assign err_code      = err_q;
  assign word_cnt      = word_cnt_q;

endmodule

// File: tb/tb_cmp_result_packer.sv
// Directed bench for cmp_result_packer: table of packed-word vectors plus
// hand-written backpressure, reset and back-to-back sequences.
module tb_cmp_result_packer;
  localparam logic [31:0] T = 32'h3F800000;
  localparam logic [31:0] F = 32'h33D6BF95;

  logic        clk = 1'b0;
  logic        rst;
  logic        err_code;
  logic [15:0] word_cnt;

  cmp_result_packer_if bus ();

  cmp_result_packer dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .err_code (err_code),
    .word_cnt (word_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_wc = 0;

  typedef struct {
    int          n;
    logic [31:0] pat;
    logic [31:0] ill;
    logic        lst;
    logic [31:0] m;
    logic [5:0]  c;
    logic [5:0]  o;
    logic        l;
    logic        e;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic xfer(input logic [31:0] d, input logic l);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_word(input string nm, input logic [31:0] m, input logic [5:0] c,
                            input logic [5:0] o, input logic l);
    chk({nm, ".valid"}, bus.out_valid, 1'b1);
    chk({nm, ".mask"},  bus.out_mask, m);
    chk({nm, ".count"}, bus.out_count, c);
    chk({nm, ".ones"},  bus.out_ones, o);
    chk({nm, ".last"},  bus.out_last, l);
  endtask

  task automatic async_reset();
    #3;
    rst = 1'b1;
    #1;
    chk("rst.valid", bus.out_valid, 1'b0);
    chk("rst.mask",  bus.out_mask, 32'd0);
    chk("rst.count", bus.out_count, 6'd0);
    chk("rst.ones",  bus.out_ones, 6'd0);
    chk("rst.last",  bus.out_last, 1'b0);
    chk("rst.err",   err_code, 1'b0);
    chk("rst.wc",    word_cnt, 16'd0);
    chk("rst.ready", bus.in_ready, 1'b1);
    #2;
    rst = 1'b0;
    exp_wc = 0;
    @(posedge clk);
    #1;
    chk("post_rst.ready", bus.in_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{32, 32'h55555555, 32'h0, 1'b0, 32'h55555555, 6'd32, 6'd16, 1'b0, 1'b0};
    vt[1] = '{4,  32'h0000000B, 32'h0, 1'b1, 32'h0000000B, 6'd4,  6'd3,  1'b1, 1'b0};
    vt[2] = '{1,  32'h00000001, 32'h0, 1'b1, 32'h00000001, 6'd1,  6'd1,  1'b1, 1'b0};
    vt[3] = '{32, 32'hFFFFFFFF, 32'h0, 1'b1, 32'hFFFFFFFF, 6'd32, 6'd32, 1'b1, 1'b0};
    vt[4] = '{5,  32'h00000000, 32'h0, 1'b1, 32'h00000000, 6'd5,  6'd0,  1'b1, 1'b0};
    vt[5] = '{3,  32'h00000005, 32'h2, 1'b1, 32'h00000005, 6'd3,  6'd2,  1'b1, 1'b1};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'd0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("init.valid", bus.out_valid, 1'b0);
    chk("init.ready", bus.in_ready, 1'b1);
    chk("init.wc",    word_cnt, 16'd0);
    chk("init.err",   err_code, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    idle_cycle();

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < vt[v].n; i++) begin
        logic [31:0] code;
        code = vt[v].ill[i] ? 32'h0 : (vt[v].pat[i] ? T : F);
        chk("vec.in_ready", bus.in_ready, 1'b1);
        if (i > 0) chk("vec.mid_valid", bus.out_valid, 1'b0);
        xfer(code, vt[v].lst && (i == vt[v].n - 1));
      end
      check_word($sformatf("vec%0d", v), vt[v].m, vt[v].c, vt[v].o, vt[v].l);
      chk($sformatf("vec%0d.err", v), err_code, vt[v].e);
      idle_cycle();
      exp_wc++;
      chk($sformatf("vec%0d.drop", v), bus.out_valid, 1'b0);
      chk($sformatf("vec%0d.wc", v), word_cnt, exp_wc[15:0]);
    end

    // err_code is sticky across later legal words
    xfer(F, 1'b1);
    check_word("sticky", 32'h0, 6'd1, 6'd0, 1'b1);
    chk("sticky.err", err_code, 1'b1);
    idle_cycle();
    chk("sticky.err2", err_code, 1'b1);

    // Partial group discarded by a mid-cycle reset
    for (int i = 0; i < 10; i++) xfer((i % 2) ? F : T, 1'b0);
    async_reset();
    bus.in_data = 32'h0;
    bus.in_last = 1'b1;
    idle_cycle();
    idle_cycle();
    bus.in_last = 1'b0;
    chk("novalid.valid", bus.out_valid, 1'b0);
    chk("novalid.err",   err_code, 1'b0);
    xfer(F, 1'b1);
    check_word("after_rst", 32'h0, 6'd1, 6'd0, 1'b1);
    idle_cycle();
    chk("after_rst.wc", word_cnt, 16'd1);

    // Backpressure with a held offered input, then no-bubble reload on release
    async_reset();
    bus.out_ready = 1'b0;
    xfer(T, 1'b0);
    xfer(T, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = T;
    bus.in_last  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check_word("bp", 32'h3, 6'd2, 6'd2, 1'b1);
      chk("bp.in_ready", bus.in_ready, 1'b0);
      chk("bp.wc", word_cnt, 16'd0);
      idle_cycle();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp.release_ready", bus.in_ready, 1'b1);
    idle_cycle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check_word("bp.next", 32'h1, 6'd1, 6'd1, 1'b1);
    chk("bp.wc1", word_cnt, 16'd1);
    chk("bp.ready1", bus.in_ready, 1'b1);
    idle_cycle();
    chk("bp.wc2", word_cnt, 16'd2);
    chk("bp.drop", bus.out_valid, 1'b0);

    // Back-to-back single-bit groups
    xfer(T, 1'b1);
    check_word("b2b.w1", 32'h1, 6'd1, 6'd1, 1'b1);
    xfer(F, 1'b1);
    check_word("b2b.w2", 32'h0, 6'd1, 6'd0, 1'b1);
    chk("b2b.wc_mid", word_cnt, 16'd3);
    idle_cycle();
    chk("b2b.wc", word_cnt, 16'd4);
    chk("b2b.drop", bus.out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
